// File: rtl/mem_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter_pkg
//   Shared definitions for the memory request arbiter: FSM state encoding,
//   memory geometry (4 banks x 1024 words x 8 bits) and a small helper used
//   to size the access phase counter.
// ---------------------------------------------------------------------------
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_CAPT  = 2'd3
  } state_t;

  // Memory geometry: address = {bank[1:0], word[9:0]}
  localparam int BANK_BITS = 2;
  localparam int WORD_BITS = 10;
  localparam int MEM_DW    = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. The winner is the first set
//   request found when scanning upward from ptr, wrapping modulo NREQ.
//   The pointer register itself lives in the parent.
// Ports
//   req     in   NREQ  request vector
//   ptr     in   IW    index with the highest priority this cycle
//   onehot  out  NREQ  one-hot winner (all zero when no request)
//   idx     out  IW    winner index (0 when no request)
//   any     out  1     at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Distance of each requester from the pointer, in scan order.
  int w_dist [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_dist
      assign w_dist[gi] = (gi >= int'(ptr)) ? (gi - int'(ptr))
                                             : (gi + NREQ - int'(ptr));
    end
  endgenerate

  int w_best;

  always_comb begin
    w_best = NREQ;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (w_dist[i] < w_best)) begin
        w_best = w_dist[i];
        idx    = IW'(i);
      end
    end
    any    = |req;
    onehot = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//   Round-robin controller sharing the single-port banked memory among NREQ
//   requesters. One access at a time: IDLE -> WRITE (WR_CYC cycles) -> IDLE,
//   or IDLE -> READ (RD_LAT cycles) -> CAPT -> IDLE. Every output is a
//   register loaded from the next-state logic, so req has no combinational
//   path to any output.
// Ports
//   clk       in   1        clock, rising edge
//   rst       in   1        asynchronous reset, active-low
//   req/we    in   NREQ     request and write flag per requester
//   addr      in   NREQ*AW  packed addresses, requester k at [k*AW +: AW]
//   wdata     in   NREQ*DW  packed write data, requester k at [k*DW +: DW]
//   gnt       out  NREQ     one-cycle acceptance pulse
//   rvalid    out  NREQ     one-cycle read data valid pulse
//   rdata     out  DW       last read data
//   busy      out  1        FSM not IDLE
//   mem_*     --           memory port (cen active-low)
// ---------------------------------------------------------------------------
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AW     = BANK_BITS + WORD_BITS,
  parameter int DW     = MEM_DW,
  parameter int WR_CYC = 2,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic                 mem_cen,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [AW-1:0]        mem_add,
  output logic [DW-1:0]        mem_din,
  input  logic [DW-1:0]        mem_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(max_int(WR_CYC, RD_LAT)) + 1;

  // Unpack the request buses so the winner can be selected by index.
  logic [AW-1:0] w_addr_arr  [NREQ];
  logic [DW-1:0] w_wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = addr[gi*AW +: AW];
      assign w_wdata_arr[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  state_t          r_state, w_state_next;
  logic [IW-1:0]   r_ptr, w_ptr_next;
  logic [IW-1:0]   r_win, w_win_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [NREQ-1:0] r_gnt, w_gnt_next;
  logic [NREQ-1:0] r_rvalid, w_rvalid_next;
  logic [DW-1:0]   r_rdata, w_rdata_next;
  logic            r_busy, w_busy_next;
  logic            r_cen, w_cen_next;
  logic            r_rd, w_rd_next;
  logic            r_wr, w_wr_next;
  logic [AW-1:0]   r_add, w_add_next;
  logic [DW-1:0]   r_din, w_din_next;

  logic [NREQ-1:0] w_win_onehot;
  logic [IW-1:0]   w_win_idx;
  logic            w_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_win_onehot),
    .idx    (w_win_idx),
    .any    (w_any)
  );

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_win_next    = r_win;
    w_cnt_next    = r_cnt;
    w_gnt_next    = '0;
    w_rvalid_next = '0;
    w_rdata_next  = r_rdata;
    w_cen_next    = 1'b1;
    w_rd_next     = 1'b0;
    w_wr_next     = 1'b0;
    w_add_next    = r_add;   // address/data hold their last value in IDLE
    w_din_next    = r_din;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_win_next = w_win_idx;
          w_ptr_next = (w_win_idx == IW'(NREQ - 1)) ? '0 : (w_win_idx + IW'(1));
          w_gnt_next = w_win_onehot;
          w_cen_next = 1'b0;
          w_add_next = w_addr_arr[w_win_idx];
          if (we[w_win_idx]) begin
            w_state_next = ST_WRITE;
            w_wr_next    = 1'b1;
            w_din_next   = w_wdata_arr[w_win_idx];
            w_cnt_next   = CW'(WR_CYC - 1);
          end else begin
            w_state_next = ST_READ;
            w_rd_next    = 1'b1;
            w_cnt_next   = CW'(RD_LAT - 1);
          end
        end
      end
      ST_WRITE: begin
        // Counter reaches zero on the last command edge; port released there.
        if (r_cnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
          w_cen_next = 1'b0;
          w_wr_next  = 1'b1;
        end
      end
      ST_READ: begin
        if (r_cnt == '0) begin
          w_state_next          = ST_CAPT;
          w_rdata_next          = mem_dout;
          w_rvalid_next[r_win]  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
          w_cen_next = 1'b0;
          w_rd_next  = 1'b1;
        end
      end
      ST_CAPT: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_cen    <= 1'b1;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_add    <= '0;
      r_din    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_win    <= w_win_next;
      r_cnt    <= w_cnt_next;
      r_gnt    <= w_gnt_next;
      r_rvalid <= w_rvalid_next;
      r_rdata  <= w_rdata_next;
      r_busy   <= w_busy_next;
      r_cen    <= w_cen_next;
      r_rd     <= w_rd_next;
      r_wr     <= w_wr_next;
      r_add    <= w_add_next;
      r_din    <= w_din_next;
    end
  end

  assign gnt     = r_gnt;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign busy    = r_busy;
  assign mem_cen = r_cen;
  assign mem_rd  = r_rd;
  assign mem_wr  = r_wr;
  assign mem_add = r_add;
  assign mem_din = r_din;

endmodule
